// File: rtl/exc_ctrl.sv
// Exception sequencer for the multi-cycle MIPS core: gates SYSCALL/BREAK/TEQ/ERET
// against CP0 Status, sequences the CP0 write strobes and redirects fetch.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | accepting decoded instructions, no CP0 activity
// EXC_COMMIT  | trap entry: write Status/Cause/EPC, flush younger work
// ERET_COMMIT | exception return: write Status/Cause, flush younger work
// REDIRECT    | fetch loads redirect_addr (handler or EPC+4)
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             is_syscall,
  input  logic             is_break,
  input  logic             is_teq,
  input  logic             teq_eq,
  input  logic             is_eret,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      status,
  input  logic [31:0]      epc_in,
  output logic             exception,
  output logic             eret,
  output logic             wsta,
  output logic             wcau,
  output logic             wepc,
  output logic [31:0]      cause,
  output logic [31:0]      epc_wr,
  output logic             pc_redirect,
  output logic [31:0]      redirect_addr,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EXC_COMMIT  = 2'd1,
    ERET_COMMIT = 2'd2,
    REDIRECT    = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       trig_sys, trig_brk, trig_teq, trig_eret, trig_trap;
  logic [4:0] exc_code;
  logic       unused_status;

  assign unused_status = ^status[31:4];

  // Priority is resolved among enabled triggers, so a disabled trap never
  // masks a lower-priority one that is allowed to fire.
  always_comb begin
    trig_sys  = valid & is_syscall & status[0] & status[1];
    trig_brk  = valid & is_break & status[0] & status[2];
    trig_teq  = valid & is_teq & teq_eq & status[0] & status[3];
    trig_eret = valid & is_eret;
    trig_trap = trig_sys | trig_brk | trig_teq;
    exc_code  = 5'd0;
    if (trig_sys)      exc_code = 5'd8;
    else if (trig_brk) exc_code = 5'd9;
    else if (trig_teq) exc_code = 5'd13;
  end

  always_comb begin
    state_nxt   = state;
    exception   = 1'b0;
    eret        = 1'b0;
    wsta        = 1'b0;
    wcau        = 1'b0;
    wepc        = 1'b0;
    pc_redirect = 1'b0;
    flush       = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (trig_trap)      state_nxt = EXC_COMMIT;
        else if (trig_eret) state_nxt = ERET_COMMIT;
      end
      EXC_COMMIT: begin
        exception = 1'b1;
        wsta      = 1'b1;
        wcau      = 1'b1;
        wepc      = 1'b1;
        flush     = 1'b1;
        state_nxt = REDIRECT;
      end
      ERET_COMMIT: begin
        eret      = 1'b1;
        wsta      = 1'b1;
        wcau      = 1'b1;
        flush     = 1'b1;
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        pc_redirect = 1'b1;
        flush       = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The redirect target is captured at acceptance so REDIRECT is a pure
  // state decode; cause/epc_wr/redirect_addr then hold until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cause         <= '0;
      epc_wr        <= '0;
      redirect_addr <= '0;
      exc_count     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (trig_trap) begin
          cause         <= {25'b0, exc_code, 2'b00};
          epc_wr        <= pc_in;
          redirect_addr <= HANDLER_ADDR;
          if (exc_count != '1) exc_count <= exc_count + CNT_W'(1);
        end else if (trig_eret) begin
          redirect_addr <= epc_in + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected CP0/redirect cycles,
// a negedge monitor pops and compares whenever the DUT drives any strobe.
module tb_exc_ctrl;

  localparam int          CW   = 4;
  localparam logic [31:0] HADR = 32'h00400004;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0, is_syscall = 1'b0, is_break = 1'b0, is_teq = 1'b0;
  logic          teq_eq = 1'b0, is_eret = 1'b0;
  logic [31:0]   pc_in = '0, status = '0, epc_in = '0;
  logic          exception, eret, wsta, wcau, wepc, pc_redirect, flush, busy;
  logic [31:0]   cause, epc_wr, redirect_addr;
  logic [CW-1:0] exc_count;

  exc_ctrl #(.HANDLER_ADDR(HADR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .valid(valid), .is_syscall(is_syscall),
    .is_break(is_break), .is_teq(is_teq), .teq_eq(teq_eq), .is_eret(is_eret),
    .pc_in(pc_in), .status(status), .epc_in(epc_in),
    .exception(exception), .eret(eret), .wsta(wsta), .wcau(wcau), .wepc(wepc),
    .cause(cause), .epc_wr(epc_wr), .pc_redirect(pc_redirect),
    .redirect_addr(redirect_addr), .flush(flush), .busy(busy),
    .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    flags;   // exception, eret, wsta, wcau, wepc, flush, pc_redirect
    logic [31:0]   cause;
    logic [31:0]   epc;
    logic [31:0]   redir;
    logic          chk_redir;
    logic [CW-1:0] cnt;
  } rec_t;

  rec_t          q[$];
  int            total = 0;
  int            bad   = 0;
  logic          mon_en = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  logic [31:0]   m_cause = '0, m_epc = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic exp_trap(input logic [31:0] pc, input logic [31:0] cw);
    rec_t r;
    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    m_cause = cw;
    m_epc   = pc;
    r.flags = 7'b1011110; r.cause = cw; r.epc = pc; r.redir = HADR;
    r.chk_redir = 1'b0; r.cnt = m_cnt;
    q.push_back(r);
    r.flags = 7'b0000011; r.chk_redir = 1'b1;
    q.push_back(r);
  endtask

  task automatic exp_eret(input logic [31:0] ret);
    rec_t r;
    r.flags = 7'b0111010; r.cause = m_cause; r.epc = m_epc; r.redir = ret;
    r.chk_redir = 1'b0; r.cnt = m_cnt;
    q.push_back(r);
    r.flags = 7'b0000011; r.chk_redir = 1'b1;
    q.push_back(r);
  endtask

  // Drive one decoded instruction for a single edge; returns #1 after that edge.
  task automatic issue(input logic [4:0] f, input logic [31:0] pc,
                       input logic [31:0] st, input logic [31:0] epc);
    {is_syscall, is_break, is_teq, teq_eq, is_eret} = f;
    pc_in = pc; status = st; epc_in = epc; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    {is_syscall, is_break, is_teq, teq_eq, is_eret} = 5'b0;
  endtask

  task automatic busy_window(input string nm);
    chk({nm, "_busy1"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk({nm, "_busy2"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic no_action(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_cnt"}, 32'(exc_count), 32'(m_cnt));
    @(posedge clk); #1;
    chk({nm, "_busy_next"}, 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    rec_t e;
    logic ok;
    if (mon_en && (exception | eret | wsta | wcau | wepc | flush | pc_redirect)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output flags=%b cause=%h epc=%h redir=%h",
                 {exception, eret, wsta, wcau, wepc, flush, pc_redirect},
                 cause, epc_wr, redirect_addr);
      end else begin
        e  = q.pop_front();
        ok = ({exception, eret, wsta, wcau, wepc, flush, pc_redirect} == e.flags) &&
             (cause == e.cause) && (epc_wr == e.epc) && (exc_count == e.cnt) &&
             (!e.chk_redir || redirect_addr == e.redir);
        if (!ok) begin
          bad++;
          $display("FAIL cp0_cycle actual flags=%b cause=%h epc=%h redir=%h cnt=%0d required flags=%b cause=%h epc=%h redir=%h cnt=%0d",
                   {exception, eret, wsta, wcau, wepc, flush, pc_redirect},
                   cause, epc_wr, redirect_addr, exc_count,
                   e.flags, e.cause, e.epc, e.redir, e.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({exception, eret, wsta, wcau, wepc, flush, pc_redirect}), 32'd0);
    chk("rst_cause", cause, 32'd0);
    chk("rst_epc", epc_wr, 32'd0);
    chk("rst_redir", redirect_addr, 32'd0);
    chk("rst_cnt", 32'(exc_count), 32'd0);

    exp_trap(32'h00400100, 32'h20);
    issue(5'b10000, 32'h00400100, 32'h0F, 32'h0);
    busy_window("syscall");
    chk("syscall_cnt", 32'(exc_count), 32'd1);

    issue(5'b01000, 32'h00400500, 32'h0B, 32'h0);
    no_action("break_dis");
    issue(5'b10000, 32'h00400600, 32'h0E, 32'h0);
    no_action("ie_off");
    issue(5'b00100, 32'h00400700, 32'h0F, 32'h0);
    no_action("teq_ne");

    exp_trap(32'h00400200, 32'h34);
    issue(5'b00110, 32'h00400200, 32'h0F, 32'h0);
    busy_window("teq");

    exp_eret(32'h00400104);
    issue(5'b00001, 32'h00400800, 32'h0F, 32'h00400100);
    busy_window("eret");
    chk("eret_cnt", 32'(exc_count), 32'd2);

    exp_eret(32'h00000000);
    issue(5'b00001, 32'h00400900, 32'h0F, 32'hFFFFFFFC);
    busy_window("eret_wrap");

    exp_trap(32'h00400300, 32'h20);
    issue(5'b11001, 32'h00400300, 32'h0F, 32'h00400100);
    busy_window("prio");

    exp_trap(32'h00400400, 32'h24);
    issue(5'b01000, 32'h00400400, 32'h0F, 32'h0);
    busy_window("break");

    // SYSCALL held across busy: the re-presented copy is the one accepted next.
    exp_trap(32'h00400A00, 32'h20);
    is_syscall = 1'b1; status = 32'h0F; pc_in = 32'h00400A00; valid = 1'b1;
    @(posedge clk); #1;
    pc_in = 32'h00400B00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_idle", 32'(busy), 32'd0);
    exp_trap(32'h00400B00, 32'h20);
    @(posedge clk); #1;
    valid = 1'b0; is_syscall = 1'b0;
    busy_window("hold_reaccept");

    exp_trap(32'h00400C00, 32'h20);
    q.pop_back();
    issue(5'b10000, 32'h00400C00, 32'h0F, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_strobes", 32'({exception, eret, wsta, wcau, wepc, flush, pc_redirect}), 32'd0);
    chk("rstmid_cause", cause, 32'd0);
    chk("rstmid_redir", redirect_addr, 32'd0);
    chk("rstmid_cnt", 32'(exc_count), 32'd0);
    rst = 1'b0;
    m_cnt = '0; m_cause = '0; m_epc = '0;
    @(posedge clk); #1;
    chk("rstmid_no_redirect", 32'(pc_redirect), 32'd0);

    for (int i = 0; i < 16; i++) begin
      exp_trap(32'h00401000 + 32'(i * 4), 32'h20);
      issue(5'b10000, 32'h00401000 + 32'(i * 4), 32'h0F, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    chk("sat_cnt", 32'(exc_count), 32'd15);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
